oclib_uart: RTL and testbench

Synthesizable, parametrised UART with TX/RX FIFOs and valid/ready byte streams. It is the RTL counterpart of the simulation UART model. It adds configurable data width, parity, stop bits, clock-derived baud divisor, error reporting, and buffering. It sits between on-chip command/debug logic and a board serial pin, and is checked against the sim UART in loopback benches.

---
 rtl/oclib_uart.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_oclib_uart.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oclib_uart.sv
`default_nettype none
// ============================================================================
// Module   : oclib_uart (with helper oclib_uart_fifo)
// Brief    : Parametrised UART, TX/RX show-ahead FIFOs, valid/ready streams.
// Revision : 1.0 - initial release
// ============================================================================

module oclib_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_ready,
  output logic                   o_valid,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr, r_rd;
  logic [c_CW-1:0]  r_count, w_count_next;
  logic             r_ready, r_valid, w_push, w_pop;

  // A pop frees a slot in the same cycle, so a full FIFO may still accept.
  assign w_pop        = i_pop && r_valid;
  assign w_push       = i_push && (r_ready || w_pop);
  assign w_count_next = r_count + c_CW'(w_push) - c_CW'(w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + c_AW'(1);
      if (w_pop)  r_rd <= r_rd + c_AW'(1);
      r_count <= w_count_next;
      r_ready <= (w_count_next != c_CW'(DEPTH));
      r_valid <= (w_count_next != '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  assign o_data  = r_valid ? r_mem[r_rd] : '0;
  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_count = r_count;
endmodule

module oclib_uart #(
  parameter int CLOCK_HZ    = 100000000,
  parameter int BAUD        = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_CYCLES = 3
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_rx,
  output logic                        o_tx,
  input  logic [DATA_BITS-1:0]        i_txData,
  input  logic                        i_txValid,
  output logic                        o_txReady,
  output logic [DATA_BITS-1:0]        o_rxData,
  output logic                        o_rxParityError,
  output logic                        o_rxValid,
  input  logic                        i_rxReady,
  output logic                        o_rxFramingError,
  output logic                        o_rxOverflow,
  output logic [$clog2(FIFO_DEPTH):0] o_txCount,
  output logic [$clog2(FIFO_DEPTH):0] o_rxCount
);
  localparam int c_DIVISOR = (CLOCK_HZ + BAUD / 2) / BAUD;
  localparam int c_CW      = $clog2(STOP_BITS * c_DIVISOR + 1);
  localparam int c_BW      = $clog2(DATA_BITS);
  localparam logic [c_CW-1:0] c_DIV_M1   = c_CW'(c_DIVISOR - 1);
  localparam logic [c_CW-1:0] c_HALF_M1  = c_CW'(c_DIVISOR / 2 - 1);
  localparam logic [c_CW-1:0] c_STOP_M1  = c_CW'(STOP_BITS * c_DIVISOR - 1);
  localparam logic [c_BW-1:0] c_LAST_BIT = c_BW'(DATA_BITS - 1);
  localparam logic            c_ODD      = (PARITY == 1);

  if (c_DIVISOR < 8) begin : g_bad_divisor
    $error("oclib_uart: baud divisor %0d is below 8", c_DIVISOR);
  end
  if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2
      || SYNC_CYCLES < 2) begin : g_bad_config
    $error("oclib_uart: unsupported frame or synchronizer configuration");
  end

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_ARM, RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP,
                            RX_BREAK} rx_state_t;

  // ---------------- TX ----------------
  tx_state_t            r_tx_state, w_tx_state;
  logic [c_CW-1:0]      r_tx_cnt, w_tx_cnt;
  logic [c_BW-1:0]      r_tx_bit, w_tx_bit;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift, w_txf_data;
  logic                 r_tx_par, w_tx_par, w_tx_load, w_txf_valid, w_tx_line;

  oclib_uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_txf (
    .i_clk(i_clock), .i_rst(i_reset), .i_push(i_txValid), .i_data(i_txData),
    .i_pop(w_tx_load), .o_data(w_txf_data), .o_ready(o_txReady),
    .o_valid(w_txf_valid), .o_count(o_txCount)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state;
      r_tx_cnt   <= w_tx_cnt;
      r_tx_bit   <= w_tx_bit;
      r_tx_shift <= w_tx_shift;
      r_tx_par   <= w_tx_par;
    end
  end

  always_comb begin
    w_tx_state = r_tx_state;
    w_tx_cnt   = r_tx_cnt;
    w_tx_bit   = r_tx_bit;
    w_tx_shift = r_tx_shift;
    w_tx_par   = r_tx_par;
    w_tx_load  = 1'b0;
    case (r_tx_state)
      TX_IDLE: w_tx_load = w_txf_valid;
      TX_START: begin
        if (r_tx_cnt == '0) begin
          w_tx_state = TX_DATA;
          w_tx_cnt   = c_DIV_M1;
          w_tx_bit   = '0;
        end else w_tx_cnt = r_tx_cnt - c_CW'(1);
      end
      TX_DATA: begin
        if (r_tx_cnt == '0) begin
          w_tx_shift = r_tx_shift >> 1;
          w_tx_cnt   = c_DIV_M1;
          if (r_tx_bit == c_LAST_BIT) begin
            if (PARITY != 0) w_tx_state = TX_PARITY;
            else begin
              w_tx_state = TX_STOP;
              w_tx_cnt   = c_STOP_M1;
            end
          end else w_tx_bit = r_tx_bit + c_BW'(1);
        end else w_tx_cnt = r_tx_cnt - c_CW'(1);
      end
      TX_PARITY: begin
        if (r_tx_cnt == '0) begin
          w_tx_state = TX_STOP;
          w_tx_cnt   = c_STOP_M1;
        end else w_tx_cnt = r_tx_cnt - c_CW'(1);
      end
      TX_STOP: begin
        if (r_tx_cnt == '0) begin
          if (w_txf_valid) w_tx_load = 1'b1;
          else w_tx_state = TX_IDLE;
        end else w_tx_cnt = r_tx_cnt - c_CW'(1);
      end
      default: w_tx_state = TX_IDLE;
    endcase
    // Loading from STOP makes back-to-back frames gapless.
    if (w_tx_load) begin
      w_tx_state = TX_START;
      w_tx_cnt   = c_DIV_M1;
      w_tx_shift = w_txf_data;
      w_tx_par   = (^w_txf_data) ^ c_ODD;
    end
  end

  always_comb begin
    case (r_tx_state)
      TX_START:  w_tx_line = 1'b0;
      TX_DATA:   w_tx_line = r_tx_shift[0];
      TX_PARITY: w_tx_line = r_tx_par;
      default:   w_tx_line = 1'b1;
    endcase
  end
  assign o_tx = w_tx_line;

  // ---------------- RX ----------------
  rx_state_t            r_rx_state, w_rx_state;
  logic [c_CW-1:0]      r_rx_cnt, w_rx_cnt;
  logic [c_BW-1:0]      r_rx_bit, w_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift;
  logic [SYNC_CYCLES-1:0] r_sync;
  logic                 r_rx_perr, w_rx_perr, w_rxs, w_rx_push, w_rx_ferr;
  logic                 w_rxf_ready, w_rxf_valid, w_rxf_drop, r_ferr, r_ovf;
  logic [DATA_BITS:0]   w_rxf_data;

  assign w_rxs      = r_sync[SYNC_CYCLES-1];
  assign w_rxf_drop = w_rx_push && !w_rxf_ready && !(i_rxReady && w_rxf_valid);

  oclib_uart_fifo #(.WIDTH(DATA_BITS + 1), .DEPTH(FIFO_DEPTH)) u_rxf (
    .i_clk(i_clock), .i_rst(i_reset), .i_push(w_rx_push),
    .i_data({r_rx_perr, r_rx_shift}), .i_pop(i_rxReady), .o_data(w_rxf_data),
    .o_ready(w_rxf_ready), .o_valid(w_rxf_valid), .o_count(o_rxCount)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync     <= '1;
      r_rx_state <= RX_ARM;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_perr  <= 1'b0;
      r_ferr     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_CYCLES-2:0], i_rx};
      r_rx_state <= w_rx_state;
      r_rx_cnt   <= w_rx_cnt;
      r_rx_bit   <= w_rx_bit;
      r_rx_shift <= w_rx_shift;
      r_rx_perr  <= w_rx_perr;
      r_ferr     <= w_rx_ferr;
      r_ovf      <= w_rxf_drop;
    end
  end

  always_comb begin
    w_rx_state = r_rx_state;
    w_rx_cnt   = r_rx_cnt;
    w_rx_bit   = r_rx_bit;
    w_rx_shift = r_rx_shift;
    w_rx_perr  = r_rx_perr;
    w_rx_push  = 1'b0;
    w_rx_ferr  = 1'b0;
    case (r_rx_state)
      // Line must idle high a full bit time before any start bit is trusted.
      RX_ARM: begin
        if (!w_rxs) w_rx_cnt = '0;
        else if (r_rx_cnt == c_DIV_M1) w_rx_state = RX_IDLE;
        else w_rx_cnt = r_rx_cnt + c_CW'(1);
      end
      RX_IDLE: begin
        if (!w_rxs) begin
          w_rx_state = RX_START;
          w_rx_cnt   = c_HALF_M1;
          w_rx_perr  = 1'b0;
        end
      end
      RX_START: begin
        if (r_rx_cnt == '0) begin
          if (w_rxs) w_rx_state = RX_IDLE;
          else begin
            w_rx_state = RX_DATA;
            w_rx_cnt   = c_DIV_M1;
            w_rx_bit   = '0;
          end
        end else w_rx_cnt = r_rx_cnt - c_CW'(1);
      end
      RX_DATA: begin
        if (r_rx_cnt == '0) begin
          w_rx_shift = {w_rxs, r_rx_shift[DATA_BITS-1:1]};
          w_rx_cnt   = c_DIV_M1;
          if (r_rx_bit == c_LAST_BIT) w_rx_state = (PARITY != 0) ? RX_PARITY : RX_STOP;
          else w_rx_bit = r_rx_bit + c_BW'(1);
        end else w_rx_cnt = r_rx_cnt - c_CW'(1);
      end
      RX_PARITY: begin
        if (r_rx_cnt == '0) begin
          w_rx_perr  = (^r_rx_shift) ^ w_rxs ^ c_ODD;
          w_rx_state = RX_STOP;
          w_rx_cnt   = c_DIV_M1;
        end else w_rx_cnt = r_rx_cnt - c_CW'(1);
      end
      RX_STOP: begin
        if (r_rx_cnt == '0) begin
          if (w_rxs) begin
            w_rx_push  = 1'b1;
            w_rx_state = RX_IDLE;
          end else begin
            w_rx_ferr  = 1'b1;
            w_rx_state = RX_BREAK;
          end
        end else w_rx_cnt = r_rx_cnt - c_CW'(1);
      end
      RX_BREAK: if (w_rxs) w_rx_state = RX_IDLE;
      default:  w_rx_state = RX_ARM;
    endcase
  end

  assign o_rxData         = w_rxf_data[DATA_BITS-1:0];
  assign o_rxParityError  = w_rxf_data[DATA_BITS];
  assign o_rxValid        = w_rxf_valid;
  assign o_rxFramingError = r_ferr;
  assign o_rxOverflow     = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_oclib_uart.sv
`default_nettype none
// ============================================================================
// Module   : tb_oclib_uart
// Brief    : Directed table-driven bench for oclib_uart (8N1 and 7E2 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_oclib_uart;
  localparam int DIV = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rx_a, tx_a, txValid_a, txReady_a, rxPerr_a, rxValid_a, rxReady_a, ferr_a, ovf_a;
  logic [7:0] txData_a, rxData_a;
  logic [2:0] txCount_a, rxCount_a;
  logic       rx_b, tx_b, txValid_b, txReady_b, rxPerr_b, rxValid_b, rxReady_b, ferr_b, ovf_b;
  logic [6:0] txData_b, rxData_b;
  logic [2:0] txCount_b, rxCount_b;

  oclib_uart #(.CLOCK_HZ(16000000), .BAUD(1000000), .DATA_BITS(8), .PARITY(0),
               .STOP_BITS(1), .FIFO_DEPTH(4), .SYNC_CYCLES(3)) u_a (
    .i_clock(clk), .i_reset(rst), .i_rx(rx_a), .o_tx(tx_a),
    .i_txData(txData_a), .i_txValid(txValid_a), .o_txReady(txReady_a),
    .o_rxData(rxData_a), .o_rxParityError(rxPerr_a), .o_rxValid(rxValid_a),
    .i_rxReady(rxReady_a), .o_rxFramingError(ferr_a), .o_rxOverflow(ovf_a),
    .o_txCount(txCount_a), .o_rxCount(rxCount_a)
  );

  oclib_uart #(.CLOCK_HZ(16000000), .BAUD(1000000), .DATA_BITS(7), .PARITY(2),
               .STOP_BITS(2), .FIFO_DEPTH(4), .SYNC_CYCLES(3)) u_b (
    .i_clock(clk), .i_reset(rst), .i_rx(rx_b), .o_tx(tx_b),
    .i_txData(txData_b), .i_txValid(txValid_b), .o_txReady(txReady_b),
    .o_rxData(rxData_b), .o_rxParityError(rxPerr_b), .o_rxValid(rxValid_b),
    .i_rxReady(rxReady_b), .o_rxFramingError(ferr_b), .o_rxOverflow(ovf_b),
    .o_txCount(txCount_b), .o_rxCount(rxCount_b)
  );

  int n_ferr_a = 0, n_ovf_a = 0, n_ferr_b = 0;
  always @(negedge clk) begin
    if (ferr_a) n_ferr_a <= n_ferr_a + 1;
    if (ovf_a)  n_ovf_a  <= n_ovf_a + 1;
    if (ferr_b) n_ferr_b <= n_ferr_b + 1;
  end

  typedef struct {
    bit         sel;        // 0: 8N1 instance, 1: 7E2 instance
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_perr;
    int         exp_ferr;
  } vec_t;

  vec_t       vt[7];
  int         errors = 0, checks = 0;
  int         bad, nr, low, f0, o0, first;
  logic       e, v, p, pb;
  logic [7:0] rb, d, pat;
  logic [9:0] frame;
  logic [6:0] txb[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  task automatic drive_bits(input bit sel, input logic [9:0] bits);
    for (int i = 0; i < 10; i++) begin
      if (sel) rx_b = bits[i]; else rx_a = bits[i];
      repeat (DIV) tick();
    end
    if (sel) rx_b = 1'b1; else rx_a = 1'b1;
  endtask

  task automatic pop(input bit sel);
    if (sel) rxReady_b = 1'b1; else rxReady_a = 1'b1;
    tick();
    rxReady_a = 1'b0;
    rxReady_b = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 0};
    vt[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1};
    vt[2] = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 0};
    vt[3] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 0};
    vt[4] = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 8'h07, 1'b1, 0};
    vt[5] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 0};
    vt[6] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1};
    txb[0] = 7'h13; txb[1] = 7'h55; txb[2] = 7'h2A; txb[3] = 7'h7F;

    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    txValid_a = 1'b0; txData_a = '0; rxReady_a = 1'b0;
    txValid_b = 1'b0; txData_b = '0; rxReady_b = 1'b0;
    tick();
    chk("reset tx_a", 32'(tx_a), 1);
    chk("reset txReady_a", 32'(txReady_a), 1);
    chk("reset rxValid_a", 32'(rxValid_a), 0);
    chk("reset rxData_a", 32'(rxData_a), 0);
    chk("reset rxParityError_a", 32'(rxPerr_a), 0);
    chk("reset pulses_a", 32'({ferr_a, ovf_a}), 0);
    chk("reset counts_a", 32'({txCount_a, rxCount_a}), 0);
    chk("reset tx_b", 32'(tx_b), 1);
    chk("reset txReady_b", 32'(txReady_b), 1);
    rst = 1'b0;
    repeat (40) tick();

    // 8N1 transmit of 0x55: exact waveform from the accept cycle
    bad = 0; first = -1; rb = '0; pat = 8'h55;
    txData_a = 8'h55; txValid_a = 1'b1;
    for (int c = 0; c < 170; c++) begin
      if (c < 2) e = 1'b1;
      else if (c < 18) e = 1'b0;
      else if (c < 146) e = pat[(c - 18) / 16];
      else e = 1'b1;
      if (tx_a !== e) begin
        if (first < 0) first = c;
        bad++;
      end
      if (c >= 18 && c < 146 && ((c - 18) % 16) == 8) rb[(c - 18) / 16] = tx_a;
      tick();
      txValid_a = 1'b0;
    end
    chk($sformatf("tx 8N1 wrong cycles (first at %0d)", first), 32'(bad), 0);
    chk("tx 8N1 decoded byte", 32'(rb), 32'h55);

    // receive vectors
    for (int i = 0; i < 7; i++) begin
      f0 = vt[i].sel ? n_ferr_b : n_ferr_a;
      if (vt[i].sel) frame = {vt[i].stop, vt[i].par, vt[i].data[6:0], 1'b0};
      else frame = {vt[i].stop, vt[i].data, 1'b0};
      drive_bits(vt[i].sel, frame);
      repeat (4) tick();
      if (vt[i].sel) begin
        v = rxValid_b; d = {1'b0, rxData_b}; p = rxPerr_b; f0 = n_ferr_b - f0;
      end else begin
        v = rxValid_a; d = rxData_a; p = rxPerr_a; f0 = n_ferr_a - f0;
      end
      chk($sformatf("rx vec%0d valid", i), 32'(v), 32'(vt[i].exp_valid));
      if (vt[i].exp_valid) begin
        chk($sformatf("rx vec%0d data", i), 32'(d), 32'(vt[i].exp_data));
        chk($sformatf("rx vec%0d parity error", i), 32'(p), 32'(vt[i].exp_perr));
        pop(vt[i].sel);
      end
      chk($sformatf("rx vec%0d framing pulses", i), 32'(f0), 32'(vt[i].exp_ferr));
    end

    // overflow: five bytes into a four-deep FIFO with no consumer
    o0 = n_ovf_a;
    for (int b = 1; b <= 5; b++) begin
      drive_bits(1'b0, {1'b1, 8'(b), 1'b0});
      repeat (4) tick();
      if (b == 4) begin
        chk("ovf rxCount after 4", 32'(rxCount_a), 4);
        chk("ovf no pulse after 4", 32'(n_ovf_a - o0), 0);
      end
    end
    chk("ovf pulse count", 32'(n_ovf_a - o0), 1);
    chk("ovf rxCount after 5", 32'(rxCount_a), 4);
    for (int b = 1; b <= 4; b++) begin
      chk($sformatf("ovf pop %0d", b), 32'(rxData_a), 32'(b));
      pop(1'b0);
    end
    chk("ovf drained", 32'(rxValid_a), 0);

    // short low glitch
    f0 = n_ferr_a;
    rx_a = 1'b0;
    repeat (4) tick();
    rx_a = 1'b1;
    repeat (40) tick();
    chk("glitch no byte", 32'(rxValid_a), 0);
    chk("glitch no framing", 32'(n_ferr_a - f0), 0);

    // 7E2 back-to-back transmit, reset mid second frame
    bad = 0; nr = 0; rb = '0; pb = 1'b0;
    for (int c = 0; c <= 250; c++) begin
      if (c < 4) begin
        txValid_b = 1'b1; txData_b = txb[c];
        if (!txReady_b) nr++;
      end else txValid_b = 1'b0;
      if ((c >= 2 && c < 18) || (c >= 178 && c < 194)) begin
        if (tx_b !== 1'b0) bad++;
      end else if (c >= 146 && c < 178) begin
        if (tx_b !== 1'b1) bad++;
      end
      if (c >= 18 && c < 130 && ((c - 18) % 16) == 8) rb[(c - 18) / 16] = tx_b;
      if (c == 138) pb = tx_b;
      if (c < 250) tick();
    end
    chk("b2b txReady while writing", 32'(nr), 0);
    chk("b2b start/stop cycles wrong", 32'(bad), 0);
    chk("b2b first byte", 32'(rb), 32'h13);
    chk("b2b first parity bit", 32'(pb), 1);
    chk("b2b txCount before reset", 32'(txCount_b), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("b2b tx after reset", 32'(tx_b), 1);
    chk("b2b txCount after reset", 32'(txCount_b), 0);
    chk("b2b txReady after reset", 32'(txReady_b), 1);
    low = 0;
    repeat (400) begin
      tick();
      if (tx_b !== 1'b1) low++;
    end
    chk("b2b no frames after reset", 32'(low), 0);

    // reset during an incoming frame, then re-arm
    rx_a = 1'b0;
    repeat (50) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    f0 = n_ferr_a;
    repeat (20) tick();
    rx_a = 1'b1;
    repeat (8) tick();
    rx_a = 1'b0;
    repeat (8) tick();
    rx_a = 1'b1;
    repeat (30) tick();
    drive_bits(1'b0, {1'b1, 8'hA3, 1'b0});
    repeat (4) tick();
    chk("rearm rxCount", 32'(rxCount_a), 1);
    chk("rearm data", 32'(rxData_a), 32'hA3);
    chk("rearm framing pulses", 32'(n_ferr_a - f0), 0);
    pop(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
